// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding and counter sizing for the scan chain sequencer
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/scan_cnt.sv
// rtl/scan_cnt.sv - loadable down counter with terminal-count flag, reused per scan phase
module scan_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so a phase can never wrap its own count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == '0);

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - load/capture/unload sequencer for one scan chain
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int   CHAIN_LEN  = 4,
  parameter int   CAP_CYCLES = 1,
  parameter logic FILL_BIT   = 1'b0
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result
);

  localparam int               CNT_W      = cnt_w(CHAIN_LEN, CAP_CYCLES);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAP_CYCLES - 1);

  state_t               r_state, w_nxt_state;
  logic [CHAIN_LEN-1:0] r_pat, r_result;
  logic                 r_scan_en, r_scan_in, r_busy, r_done;
  logic                 w_se, w_si, w_busy, w_done;
  logic                 w_load, w_dec, w_pat_load, w_tc;
  logic [CNT_W-1:0]     w_load_val, w_cnt, w_cnt_m1;

  scan_cnt #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (r),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // The counter runs down, so it doubles as the MSB-first pattern index.
  assign w_cnt_m1 = w_cnt - 1'b1;

  // Outputs are decoded for the coming cycle and then registered.
  always_comb begin
    w_nxt_state = r_state;
    w_se        = 1'b0;
    w_si        = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    w_pat_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_state = S_LOAD;
          w_pat_load  = 1'b1;
          w_load      = 1'b1;
          w_load_val  = SHIFT_LAST;
          w_se        = 1'b1;
          w_si        = pattern_in[CHAIN_LEN-1];
          w_busy      = 1'b1;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        if (w_tc) begin
          w_nxt_state = S_CAPTURE;
          w_load      = 1'b1;
          w_load_val  = CAP_LAST;
        end else begin
          w_dec = 1'b1;
          w_se  = 1'b1;
          w_si  = r_pat[w_cnt_m1];
        end
      end
      S_CAPTURE: begin
        w_busy = 1'b1;
        if (w_tc) begin
          w_nxt_state = S_UNLOAD;
          w_load      = 1'b1;
          w_load_val  = SHIFT_LAST;
          w_se        = 1'b1;
          w_si        = FILL_BIT;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_UNLOAD: begin
        if (w_tc) begin
          w_nxt_state = S_DONE;
          w_done      = 1'b1;
        end else begin
          w_dec  = 1'b1;
          w_se   = 1'b1;
          w_si   = FILL_BIT;
          w_busy = 1'b1;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state   <= S_IDLE;
      r_scan_en <= 1'b0;
      r_scan_in <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pat     <= '0;
      r_result  <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_scan_en <= w_se;
      r_scan_in <= w_si;
      r_busy    <= w_busy;
      r_done    <= w_done;
      if (w_pat_load) r_pat <= pattern_in;
      if (r_state == S_UNLOAD) r_result <= {r_result[CHAIN_LEN-2:0], scan_out};
    end
  end

  assign scan_en = r_scan_en;
  assign scan_in = r_scan_in;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - directed bench for scan_chain_ctrl with behavioural chain models
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic       start_a, so_a, se_a, si_a, busy_a, done_a;
  logic [3:0] pat_a, res_a;
  logic       start_b, so_b, se_b, si_b, busy_b, done_b;
  logic [7:0] pat_b, res_b;

  logic [3:0] ch_a = '0, pi_a = '0;
  logic       cap_a = 1'b0;
  logic [7:0] ch_b = '0, pi_b = '0;
  logic       cap_b = 1'b0;

  int tests_run = 0;
  int fails = 0;

  localparam logic [10:0] SE_A = 11'b11110111100;

  scan_chain_ctrl #(.CHAIN_LEN(4), .CAP_CYCLES(1), .FILL_BIT(1'b0)) u_dut_a (
    .clk(clk), .r(r), .start(start_a), .pattern_in(pat_a), .scan_out(so_a),
    .scan_en(se_a), .scan_in(si_a), .busy(busy_a), .done(done_a), .result(res_a)
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(3), .FILL_BIT(1'b0)) u_dut_b (
    .clk(clk), .r(r), .start(start_b), .pattern_in(pat_b), .scan_out(so_b),
    .scan_en(se_b), .scan_in(si_b), .busy(busy_b), .done(done_b), .result(res_b)
  );

  // Scan chains: shift toward the MSB when scan_en is high, capture pi otherwise.
  always @(posedge clk) begin
    if (se_a) ch_a <= {ch_a[2:0], si_a};
    else if (cap_a) ch_a <= pi_a;
    if (se_b) ch_b <= {ch_b[6:0], si_b};
    else if (cap_b) ch_b <= pi_b;
  end
  assign so_a = ch_a[3];
  assign so_b = ch_b[7];

  task automatic wait_done_a(output int n);
    n = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({se_a, si_a, busy_a, done_a, res_a} !== 8'h00) begin
      fails++;
      $display("FAIL reset_state got %b exp 00000000", {se_a, si_a, busy_a, done_a, res_a});
    end
    tests_run++;
    if ({se_b, busy_b, done_b, res_b} !== 11'h000) begin
      fails++;
      $display("FAIL reset_state_b got %b exp 0", {se_b, busy_b, done_b, res_b});
    end
    r = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    logic [3:0] pat;
    pat = 4'b1011;
    cap_a = 1'b0;
    pat_a = pat; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; pat_a = 4'b0000;
    for (int k = 0; k <= 10; k++) begin
      tests_run++;
      if (se_a !== SE_A[10-k]) begin
        fails++;
        $display("FAIL timing_scan_en k=%0d got %b exp %b", k, se_a, SE_A[10-k]);
      end
      tests_run++;
      if (busy_a !== (k < 9)) begin
        fails++;
        $display("FAIL timing_busy k=%0d got %b exp %b", k, busy_a, (k < 9));
      end
      tests_run++;
      if (done_a !== (k == 9)) begin
        fails++;
        $display("FAIL timing_done k=%0d got %b exp %b", k, done_a, (k == 9));
      end
      if (k < 4) begin
        tests_run++;
        if (si_a !== pat[3-k]) begin
          fails++;
          $display("FAIL timing_scan_in k=%0d got %b exp %b", k, si_a, pat[3-k]);
        end
      end
      if (k < 10) @(negedge clk);
    end
    tests_run++;
    if (res_a !== 4'b1011) begin
      fails++;
      $display("FAIL no_capture_result got %b exp 1011", res_a);
    end
  endtask

  task automatic test_datapath();
    int n;
    cap_a = 1'b1; pi_a = 4'b0110;
    pat_a = 4'b1011; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(n);
    tests_run++;
    if (n != 8) begin
      fails++;
      $display("FAIL datapath_latency got %0d exp 8", n);
    end
    tests_run++;
    if (res_a !== 4'b0110) begin
      fails++;
      $display("FAIL datapath_result got %b exp 0110", res_a);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (res_a !== 4'b0110) begin
      fails++;
      $display("FAIL result_hold got %b exp 0110", res_a);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    cap_a = 1'b1; pi_a = 4'b1001;
    pat_a = 4'b1011; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    #2 r = 1'b0;
    #1;
    tests_run++;
    if ({se_a, si_a, busy_a, done_a, res_a} !== 8'h00) begin
      fails++;
      $display("FAIL reset_async got %b exp 00000000", {se_a, si_a, busy_a, done_a, res_a});
    end
    @(negedge clk);
    r = 1'b1;
    @(negedge clk);
    pat_a = 4'b1011; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(n);
    tests_run++;
    if (n != 8 || res_a !== 4'b1001) begin
      fails++;
      $display("FAIL reset_restart got n=%0d res=%b exp n=8 res=1001", n, res_a);
    end
  endtask

  task automatic test_start_busy();
    int ndone;
    ndone = 0;
    cap_a = 1'b1; pi_a = 4'b1100;
    pat_a = 4'b0011; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) begin
        start_a = 1'b1; pat_a = 4'b0000;
      end
      if (k == 5) begin
        start_a = 1'b0;
        tests_run++;
        if (se_a !== 1'b1 || si_a !== 1'b0) begin
          fails++;
          $display("FAIL busy_start_unload got se=%b si=%b exp se=1 si=0", se_a, si_a);
        end
      end
      if (k == 12) begin
        tests_run++;
        if (busy_a !== 1'b0) begin
          fails++;
          $display("FAIL busy_start_restart got busy=%b exp 0", busy_a);
        end
      end
      if (done_a === 1'b1) ndone++;
    end
    tests_run++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL busy_start_done_count got %0d exp 1", ndone);
    end
    tests_run++;
    if (res_a !== 4'b1100) begin
      fails++;
      $display("FAIL busy_start_result got %b exp 1100", res_a);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] pat2;
    pat2 = 4'b0101;
    cap_a = 1'b1; pi_a = 4'b0110;
    pat_a = 4'b1011; start_a = 1'b1;
    wait_done_a(n);
    tests_run++;
    if (n < 0 || res_a !== 4'b0110) begin
      fails++;
      $display("FAIL b2b_first got n=%0d res=%b exp res=0110", n, res_a);
    end
    pat_a = pat2; pi_a = 4'b0011;
    @(negedge clk);
    tests_run++;
    if (se_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap got se=%b busy=%b done=%b exp 000", se_a, busy_a, done_a);
    end
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      tests_run++;
      if (busy_a !== 1'b1 || se_a !== 1'b1 || si_a !== pat2[3-k]) begin
        fails++;
        $display("FAIL b2b_load k=%0d got busy=%b se=%b si=%b exp si=%b", k, busy_a, se_a, si_a, pat2[3-k]);
      end
    end
    wait_done_a(n);
    tests_run++;
    if (n < 0 || res_a !== 4'b0011) begin
      fails++;
      $display("FAIL b2b_second got n=%0d res=%b exp res=0011", n, res_a);
    end
  endtask

  task automatic test_long_chain();
    logic [7:0] pat;
    int busy_cnt, gap_cnt;
    pat = 8'hA5; busy_cnt = 0; gap_cnt = 0;
    cap_b = 1'b1; pi_b = 8'h3C;
    pat_b = pat; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k <= 19; k++) begin
      tests_run++;
      if (se_b !== ((k < 8) || (k >= 11 && k < 19))) begin
        fails++;
        $display("FAIL long_scan_en k=%0d got %b", k, se_b);
      end
      if (k < 8) begin
        tests_run++;
        if (si_b !== pat[7-k]) begin
          fails++;
          $display("FAIL long_scan_in k=%0d got %b exp %b", k, si_b, pat[7-k]);
        end
      end
      if (busy_b === 1'b1) busy_cnt++;
      if (busy_b === 1'b1 && se_b === 1'b0) gap_cnt++;
      if (k == 19) begin
        tests_run++;
        if (done_b !== 1'b1) begin
          fails++;
          $display("FAIL long_done got %b exp 1", done_b);
        end
      end
      if (k < 19) @(negedge clk);
    end
    tests_run++;
    if (busy_cnt != 19 || gap_cnt != 3) begin
      fails++;
      $display("FAIL long_counts got busy=%0d gap=%0d exp busy=19 gap=3", busy_cnt, gap_cnt);
    end
    tests_run++;
    if (res_b !== 8'h3C) begin
      fails++;
      $display("FAIL long_result got %h exp 3c", res_b);
    end
  endtask

  initial begin
    r = 1'b0;
    start_a = 1'b0; pat_a = '0;
    start_b = 1'b0; pat_b = '0;
    test_reset();
    test_timing();
    @(negedge clk);
    test_datapath();
    test_reset_mid();
    @(negedge clk);
    test_start_busy();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_long_chain();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
